// File: rtl/spi_flash.sv
`default_nettype none
// ============================================================================
//  Module   : spi_flash
//  Purpose  : SPI flash emulator (mode 0 slave) serving read commands from a
//             32-bit wide BRAM. Supports READ (0x03) and, optionally,
//             FAST READ (0x0B) with 8 dummy clocks. Continuous reads stream
//             successive bytes, wrapping the 24-bit address space.
//  Macro    : SPIFLASH_FASTREAD_EN - when defined, enables FAST READ (0x0B)
//             and the DUMMY state. Undefined: 0x0B is an unknown command.
//  Ports    : ap_clk, ap_rst     - system clock / sync active-high reset
//             csb, spiclk, io0   - SPI inputs (asynchronous to ap_clk)
//             io1                - SPI MISO
//             romcode_*_A        - BRAM port A (read only, byte address)
//  Revision : 1.0 - initial release
// ============================================================================
module spi_flash (
  input  logic        ap_clk,
  input  logic        ap_rst,
  input  logic        csb,
  input  logic        spiclk,
  input  logic        io0,
  output logic        io1,
  output logic [31:0] romcode_Addr_A,
  output logic        romcode_EN_A,
  output logic [3:0]  romcode_WEN_A,
  output logic [31:0] romcode_Din_A,
  input  logic [31:0] romcode_Dout_A,
  output logic        romcode_Clk_A,
  output logic        romcode_Rst_A
);

  localparam logic [7:0] CMD_READ = 8'h03;
`ifdef SPIFLASH_FASTREAD_EN
  localparam logic [7:0] CMD_FAST = 8'h0B;
`endif

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CMD    = 3'd1,
    S_ADDR   = 3'd2,
`ifdef SPIFLASH_FASTREAD_EN
    S_DUMMY  = 3'd3,
`endif
    S_DATA   = 3'd4,
    S_IGNORE = 3'd5
  } state_t;

  state_t      state;
  state_t      state_nxt;

  // Synchronisers
  logic        csb_m, csb_s;
  logic        sclk_m, sclk_s, sclk_d;
  logic        io0_m, io0_s;

  logic        cs_act;
  logic        sclk_rise;
  logic        sclk_fall;

  logic [4:0]  bit_cnt;
  logic [22:0] shift_in;
  logic [23:0] addr;
  logic [23:0] addr_inc;
  logic [7:0]  out_sr;
  logic [31:0] word;
  logic        fetch_d;   // BRAM data valid this cycle
  logic        reuse_ld;  // load next byte from the held word
  logic        primed;    // initial fetch of this DATA phase issued
  logic [7:0]  cmd_byte;
`ifdef SPIFLASH_FASTREAD_EN
  logic        fast;
`endif

  assign cs_act    = ~csb_s;
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cmd_byte  = {shift_in[6:0], io0_s};
  assign addr_inc  = addr + 24'd1;

  assign romcode_WEN_A = 4'b0000;
  assign romcode_Din_A = 32'h0000_0000;
  assign romcode_Clk_A = ap_clk;
  assign romcode_Rst_A = ap_rst;

  // Little-endian byte lane select
  function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] sel);
    case (sel)
      2'd0:    pick_byte = w[7:0];
      2'd1:    pick_byte = w[15:8];
      2'd2:    pick_byte = w[23:16];
      default: pick_byte = w[31:24];
    endcase
  endfunction

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    if (!cs_act) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: state_nxt = S_CMD;
        S_CMD: begin
          if (sclk_rise && bit_cnt == 5'd7) begin
            state_nxt = S_IGNORE;
            if (cmd_byte == CMD_READ) state_nxt = S_ADDR;
`ifdef SPIFLASH_FASTREAD_EN
            if (cmd_byte == CMD_FAST) state_nxt = S_ADDR;
`endif
          end
        end
        S_ADDR: begin
          if (sclk_rise && bit_cnt == 5'd23) begin
`ifdef SPIFLASH_FASTREAD_EN
            state_nxt = fast ? S_DUMMY : S_DATA;
`else
            state_nxt = S_DATA;
`endif
          end
        end
`ifdef SPIFLASH_FASTREAD_EN
        S_DUMMY: begin
          if (sclk_rise && bit_cnt == 5'd7) state_nxt = S_DATA;
        end
`endif
        default: state_nxt = state;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Datapath: synchronisers, shifting, BRAM fetch and MISO output
  // --------------------------------------------------------------------------
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      csb_m          <= 1'b1;
      csb_s          <= 1'b1;
      sclk_m         <= 1'b0;
      sclk_s         <= 1'b0;
      sclk_d         <= 1'b0;
      io0_m          <= 1'b0;
      io0_s          <= 1'b0;
      bit_cnt        <= 5'd0;
      shift_in       <= 23'd0;
      addr           <= 24'd0;
      out_sr         <= 8'd0;
      word           <= 32'd0;
      io1            <= 1'b0;
      romcode_EN_A   <= 1'b0;
      romcode_Addr_A <= 32'd0;
      fetch_d        <= 1'b0;
      reuse_ld       <= 1'b0;
      primed         <= 1'b0;
`ifdef SPIFLASH_FASTREAD_EN
      fast           <= 1'b0;
`endif
    end else begin
      csb_m  <= csb;
      csb_s  <= csb_m;
      sclk_m <= spiclk;
      sclk_s <= sclk_m;
      sclk_d <= sclk_s;
      io0_m  <= io0;
      io0_s  <= io0_m;

      romcode_EN_A <= 1'b0;
      fetch_d      <= romcode_EN_A;
      reuse_ld     <= 1'b0;

      if (!cs_act) begin
        bit_cnt  <= 5'd0;
        shift_in <= 23'd0;
        io1      <= 1'b0;
        primed   <= 1'b0;
      end else begin
        case (state)
          S_CMD: begin
            if (sclk_rise) begin
              shift_in <= {shift_in[21:0], io0_s};
              if (bit_cnt == 5'd7) begin
                bit_cnt <= 5'd0;
`ifdef SPIFLASH_FASTREAD_EN
                fast    <= (cmd_byte == CMD_FAST);
`endif
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end
          S_ADDR: begin
            if (sclk_rise) begin
              shift_in <= {shift_in[21:0], io0_s};
              if (bit_cnt == 5'd23) begin
                addr    <= {shift_in, io0_s};
                bit_cnt <= 5'd0;
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end
`ifdef SPIFLASH_FASTREAD_EN
          S_DUMMY: begin
            if (sclk_rise) begin
              bit_cnt <= (bit_cnt == 5'd7) ? 5'd0 : bit_cnt + 5'd1;
            end
          end
`endif
          S_DATA: begin
            if (!primed) begin
              // First cycle in DATA: fetch the word holding the start byte.
              primed         <= 1'b1;
              romcode_EN_A   <= 1'b1;
              romcode_Addr_A <= {8'h00, addr[23:2], 2'b00};
            end else if (sclk_fall) begin
              io1    <= out_sr[7];
              out_sr <= {out_sr[6:0], 1'b0};
              if (bit_cnt == 5'd7) begin
                // Byte complete: advance and prepare the next byte well
                // before the following falling edge.
                bit_cnt <= 5'd0;
                addr    <= addr_inc;
                if (addr[1:0] == 2'b11) begin
                  romcode_EN_A   <= 1'b1;
                  romcode_Addr_A <= {8'h00, addr_inc[23:2], 2'b00};
                end else begin
                  reuse_ld <= 1'b1;
                end
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end
          default: ;
        endcase
      end

      // Byte loads come after the shift so a load always takes effect.
      if (fetch_d) begin
        word   <= romcode_Dout_A;
        out_sr <= pick_byte(romcode_Dout_A, addr[1:0]);
      end
      if (reuse_ld) begin
        out_sr <= pick_byte(word, addr[1:0]);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_flash.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_flash
//  Purpose  : Self-checking bench for spi_flash. Drives SPI mode 0 master
//             transactions, models the BRAM, and compares received bytes
//             against a queue of expected bytes.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_flash;

  localparam int HALF = 8;

  logic        ap_clk = 1'b0;
  logic        ap_rst = 1'b1;
  logic        csb    = 1'b1;
  logic        spiclk = 1'b0;
  logic        io0    = 1'b0;
  logic        io1;
  logic [31:0] romcode_Addr_A;
  logic        romcode_EN_A;
  logic [3:0]  romcode_WEN_A;
  logic [31:0] romcode_Din_A;
  logic [31:0] romcode_Dout_A = 32'h0;
  logic        romcode_Clk_A;
  logic        romcode_Rst_A;

  spi_flash dut (
    .ap_clk         (ap_clk),
    .ap_rst         (ap_rst),
    .csb            (csb),
    .spiclk         (spiclk),
    .io0            (io0),
    .io1            (io1),
    .romcode_Addr_A (romcode_Addr_A),
    .romcode_EN_A   (romcode_EN_A),
    .romcode_WEN_A  (romcode_WEN_A),
    .romcode_Din_A  (romcode_Din_A),
    .romcode_Dout_A (romcode_Dout_A),
    .romcode_Clk_A  (romcode_Clk_A),
    .romcode_Rst_A  (romcode_Rst_A)
  );

  always #5 ap_clk = ~ap_clk;

  // BRAM model: 16 words, one-cycle read latency
  logic [31:0] mem [16];
  always @(posedge ap_clk) begin
    if (romcode_EN_A) romcode_Dout_A <= mem[romcode_Addr_A[5:2]];
  end

  // Fetch / MISO monitors
  int          fetch_cnt  = 0;
  logic [31:0] fetch_log [64];
  int          en_run_err = 0;
  logic        en_prev    = 1'b0;
  int          io1_hi     = 0;
  always @(posedge ap_clk) begin
    if (romcode_EN_A) begin
      if (fetch_cnt < 64) fetch_log[fetch_cnt] = romcode_Addr_A;
      fetch_cnt++;
    end
    if (romcode_EN_A && en_prev) en_run_err++;
    en_prev = romcode_EN_A;
    if (io1) io1_hi++;
  end

  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_q [$];
  logic [7:0] rx;
  int         f0;
  int         h0;
  logic [7:0] rx_or;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic spi_bit(input logic mosi, output logic miso);
    io0 = mosi;
    repeat (HALF) @(negedge ap_clk);
    miso   = io1;
    spiclk = 1'b1;
    repeat (HALF) @(negedge ap_clk);
    spiclk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rxb);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], b);
      rxb[i] = b;
    end
  endtask

  task automatic cs_start();
    csb = 1'b0;
    repeat (4) @(negedge ap_clk);
  endtask

  task automatic cs_end();
    repeat (HALF) @(negedge ap_clk);
    csb = 1'b1;
    io0 = 1'b0;
    repeat (8) @(negedge ap_clk);
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] a);
    logic [7:0] d;
    spi_byte(cmd, d);
    spi_byte(a[23:16], d);
    spi_byte(a[15:8], d);
    spi_byte(a[7:0], d);
  endtask

  // Clock out n bytes and compare each against the scoreboard head
  task automatic read_check(input string tag, input int n);
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      spi_byte(8'h00, d);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL %s: observed %0h with no expected byte queued", tag, d);
      end else begin
        check($sformatf("%s[%0d]", tag, i), {24'h0, d}, {24'h0, exp_q.pop_front()});
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[0]  = 32'h1234_5678;
    mem[1]  = 32'hCAFE_F00D;
    mem[2]  = 32'h55AA_33CC;
    mem[15] = 32'hA1B2_C3D4;

    // ---------------- reset state ----------------
    repeat (5) @(negedge ap_clk);
    check("rst_io1",  {31'h0, io1}, 32'h0);
    check("rst_en",   {31'h0, romcode_EN_A}, 32'h0);
    check("rst_addr", romcode_Addr_A, 32'h0);
    check("rst_wen",  {28'h0, romcode_WEN_A}, 32'h0);
    check("rst_din",  romcode_Din_A, 32'h0);
    check("rst_rsta", {31'h0, romcode_Rst_A}, 32'h1);
    check("clk_a",    {31'h0, romcode_Clk_A}, {31'h0, ap_clk});
    ap_rst = 1'b0;
    repeat (4) @(negedge ap_clk);
    check("rsta_rel", {31'h0, romcode_Rst_A}, 32'h0);

    // ---------------- READ at 0x000000, 8 bytes ----------------
    f0 = fetch_cnt;
    cs_start();
    send_hdr(8'h03, 24'h000000);
    exp_q.push_back(8'h78); exp_q.push_back(8'h56);
    exp_q.push_back(8'h34); exp_q.push_back(8'h12);
    exp_q.push_back(8'h0D); exp_q.push_back(8'hF0);
    exp_q.push_back(8'hFE); exp_q.push_back(8'hCA);
    read_check("rd0", 8);
    cs_end();
    check("rd0_fetch0", fetch_log[f0], 32'h0);
    check("rd0_fetch1", fetch_log[f0+1], 32'h4);
    check("rd0_io1_idle", {31'h0, io1}, 32'h0);

    // ---------------- READ at 0x000003, 2 bytes ----------------
    f0 = fetch_cnt;
    cs_start();
    send_hdr(8'h03, 24'h000003);
    exp_q.push_back(8'h12); exp_q.push_back(8'h0D);
    read_check("rd3", 2);
    cs_end();
    check("rd3_nfetch", fetch_cnt - f0, 2);
    check("rd3_fetch0", fetch_log[f0], 32'h0);
    check("rd3_fetch1", fetch_log[f0+1], 32'h4);

    // ---------------- unknown command 0x9F ----------------
    f0 = fetch_cnt; h0 = io1_hi; rx_or = 8'h00;
    cs_start();
    spi_byte(8'h9F, rx);
    for (int i = 0; i < 4; i++) begin
      spi_byte(8'hFF, rx);
      rx_or = rx_or | rx;
    end
    cs_end();
    check("9f_rx", {24'h0, rx_or}, 32'h0);
    check("9f_io1_hi", io1_hi - h0, 0);
    check("9f_nfetch", fetch_cnt - f0, 0);
    cs_start();
    send_hdr(8'h03, 24'h000004);
    exp_q.push_back(8'h0D);
    read_check("rd4", 1);
    cs_end();

    // ---------------- aborted command, then READ at 0x000001 ----------------
    cs_start();
    for (int i = 0; i < 5; i++) spi_bit(1'b0, rx[0]);
    cs_end();
    cs_start();
    send_hdr(8'h03, 24'h000001);
    exp_q.push_back(8'h56);
    read_check("rd1", 1);
    cs_end();

    // ---------------- reset during DATA ----------------
    cs_start();
    send_hdr(8'h03, 24'h000008);
    spi_bit(1'b0, rx[0]);        // byte 0xCC: bit6 now on io1
    repeat (5) @(negedge ap_clk);
    check("pre_rst_io1",  {31'h0, io1}, 32'h1);
    check("pre_rst_addr", romcode_Addr_A, 32'h8);
    ap_rst = 1'b1;
    @(negedge ap_clk);
    check("mid_rst_io1",  {31'h0, io1}, 32'h0);
    check("mid_rst_en",   {31'h0, romcode_EN_A}, 32'h0);
    check("mid_rst_addr", romcode_Addr_A, 32'h0);
    csb    = 1'b1;
    repeat (2) @(negedge ap_clk);
    ap_rst = 1'b0;
    repeat (8) @(negedge ap_clk);
    cs_start();
    send_hdr(8'h03, 24'h000004);
    exp_q.push_back(8'h0D);
    read_check("post_rst", 1);
    cs_end();

    // ---------------- address wrap 0xFFFFFF -> 0x000000 ----------------
    f0 = fetch_cnt;
    cs_start();
    send_hdr(8'h03, 24'hFFFFFF);
    exp_q.push_back(8'hA1); exp_q.push_back(8'h78);
    read_check("wrap", 2);
    cs_end();
    check("wrap_nfetch", fetch_cnt - f0, 2);
    check("wrap_fetch0", fetch_log[f0], 32'h00FF_FFFC);
    check("wrap_fetch1", fetch_log[f0+1], 32'h0);

    // ---------------- FAST READ 0x0B ----------------
    f0 = fetch_cnt; h0 = io1_hi;
    cs_start();
    send_hdr(8'h0B, 24'h000000);
    spi_byte(8'h00, rx);         // 8 dummy clocks
`ifdef SPIFLASH_FASTREAD_EN
    exp_q.push_back(8'h78); exp_q.push_back(8'h56);
`else
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
`endif
    read_check("fast", 2);
    cs_end();
`ifdef SPIFLASH_FASTREAD_EN
    check("fast_fetch0", fetch_log[f0], 32'h0);
`else
    check("fast_io1_hi", io1_hi - h0, 0);
    check("fast_nfetch", fetch_cnt - f0, 0);
`endif

    // ---------------- global properties ----------------
    check("en_single_cycle", en_run_err, 0);
    check("wen_const", {28'h0, romcode_WEN_A}, 32'h0);
    check("din_const", romcode_Din_A, 32'h0);
    check("sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
